piso_tx: RTL and testbench

//   Parallel-in serial-out transmitter; the serialising counterpart of the sipo block.

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_tx.sv | 90 +++++++++
 tb/tb_piso_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } piso_state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word over valid/ready and
// streams it one bit per enabled clock with so_valid/so_last framing.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PI,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             en,
    output logic             SO,
    output logic             so_valid,
    output logic             so_last
);

    localparam int CNT_W = cnt_w(WIDTH);

    piso_state_e      state;
    piso_state_e      state_next;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             accept;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load may land on the final enabled bit of a word, so words can abut with no gap.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        SO         = 1'b0;
        so_valid   = 1'b0;
        so_last    = 1'b0;
        accept     = 1'b0;

        unique case (state)
            IDLE: begin
                load_ready = !rst;
            end
            SHIFT: begin
                load_ready = !rst && cnt_zero && en;
                so_valid   = 1'b1;
                so_last    = cnt_zero;
                SO         = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        accept = load_valid && load_ready;

        if (accept) begin
            state_next = SHIFT;
        end else if (state == SHIFT && cnt_zero && en) begin
            state_next = IDLE;
        end
    end

    // The counter only decrements while non-zero, so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= PI;
            cnt   <= CNT_W'(WIDTH - 1);
        end else if (state == SHIFT && en && !cnt_zero) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed scenarios plus a randomized run scored
// against a bit-queue model of the transmitter.
module tb_piso_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pi_a, pi_b;
    logic         lv_a, lv_b, en_a, en_b;
    logic         ready_a, so_a, valid_a, last_a;
    logic         ready_b, so_b, valid_b, last_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the bits still to be sent for the word in flight, head first.
    bit m_q[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .PI(pi_a), .load_valid(lv_a), .load_ready(ready_a),
        .en(en_a), .SO(so_a), .so_valid(valid_a), .so_last(last_a)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .PI(pi_b), .load_valid(lv_b), .load_ready(ready_b),
        .en(en_b), .SO(so_b), .so_valid(valid_b), .so_last(last_b)
    );

    function automatic void model_load(input logic [W-1:0] w);
        m_q.delete();
        for (int i = 0; i < W; i++) m_q.push_back(w[W-1-i]);
    endfunction

    task automatic test_reset();
        rst = 1'b1; lv_a = 0; en_a = 0; pi_a = '0; lv_b = 0; en_b = 0; pi_b = '0;
        @(negedge clk);
        n_checks++; if (so_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_so: got %b expected 0", so_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_a); end
        n_checks++; if (last_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_last: got %b expected 0", last_a); end
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_a); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("[TB] FAIL release_ready: got %b expected 1", ready_a); end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [W-1:0] exp_bits;
        exp_bits = 4'b1011;
        pi_a = 4'b1011; lv_a = 1; en_a = 1;
        @(negedge clk);
        lv_a = 0;
        for (int k = 0; k < W; k++) begin
            #1;
            n_checks++; if (so_a !== exp_bits[W-1-k]) begin n_fail++; $display("[TB] FAIL single_so[%0d]: got %b expected %b", k, so_a, exp_bits[W-1-k]); end
            n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid[%0d]: got %b expected 1", k, valid_a); end
            n_checks++; if (last_a !== (k == W-1)) begin n_fail++; $display("[TB] FAIL single_last[%0d]: got %b expected %b", k, last_a, k == W-1); end
            @(negedge clk);
        end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL single_valid_after: got %b expected 0", valid_a); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bits;
        exp_bits = 8'b1011_0110;
        pi_a = 4'b1011; lv_a = 1; en_a = 1;
        @(negedge clk);
        pi_a = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++; if (so_a !== exp_bits[7-k]) begin n_fail++; $display("[TB] FAIL b2b_so[%0d]: got %b expected %b", k, so_a, exp_bits[7-k]); end
            n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", k, valid_a); end
            if (k < 7) begin
                n_checks++; if (ready_a !== (k == 3)) begin n_fail++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", k, ready_a, k == 3); end
            end
            @(negedge clk);
            if (k == 3) lv_a = 0;
        end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_valid_after: got %b expected 0", valid_a); end
    endtask

    task automatic test_stall();
        logic [5:0] en_pat, exp_so, exp_last;
        en_pat   = 6'b100111;
        exp_so   = 6'b100011;
        exp_last = 6'b000001;
        pi_a = 4'b1011; lv_a = 1; en_a = 1;
        @(negedge clk);
        lv_a = 0;
        for (int k = 0; k < 6; k++) begin
            en_a = en_pat[5-k];
            #1;
            n_checks++; if (so_a !== exp_so[5-k]) begin n_fail++; $display("[TB] FAIL stall_so[%0d]: got %b expected %b", k, so_a, exp_so[5-k]); end
            n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", k, valid_a); end
            n_checks++; if (last_a !== exp_last[5-k]) begin n_fail++; $display("[TB] FAIL stall_last[%0d]: got %b expected %b", k, last_a, exp_last[5-k]); end
            @(negedge clk);
        end
        en_a = 1;
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_valid_after: got %b expected 0", valid_a); end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] exp_bits;
        pi_a = 4'b1011; lv_a = 1; en_a = 1;
        @(negedge clk);
        lv_a = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (so_a !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_so: got %b expected 0", so_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_valid: got %b expected 0", valid_a); end
        @(negedge clk);
        rst = 1'b0;
        exp_bits = 4'b0101;
        pi_a = exp_bits; lv_a = 1;
        @(negedge clk);
        lv_a = 0;
        for (int k = 0; k < W; k++) begin
            #1;
            n_checks++; if (so_a !== exp_bits[W-1-k] || valid_a !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_reload[%0d]: got so=%b valid=%b expected so=%b valid=1", k, so_a, valid_a, exp_bits[W-1-k]); end
            n_checks++; if (last_a !== (k == W-1)) begin n_fail++; $display("[TB] FAIL midrst_last[%0d]: got %b expected %b", k, last_a, k == W-1); end
            @(negedge clk);
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] rx;
        logic [W-1:0] exp_b;
        rx = '0;
        pi_a = 4'b1011; lv_a = 1; en_a = 1;
        @(negedge clk);
        lv_a = 0;
        for (int k = 0; k < W + 1; k++) begin
            if (valid_a) rx = {rx[W-2:0], so_a};
            @(negedge clk);
        end
        n_checks++; if (rx !== 4'b1011) begin n_fail++; $display("[TB] FAIL loopback_po: got %b expected 1011", rx); end

        exp_b = 4'b1101;
        pi_b = exp_b; lv_b = 1; en_b = 1;
        @(negedge clk);
        lv_b = 0;
        for (int k = 0; k < W; k++) begin
            #1;
            n_checks++; if (so_b !== exp_b[k] || valid_b !== 1'b1) begin n_fail++; $display("[TB] FAIL lsb_so[%0d]: got so=%b valid=%b expected so=%b valid=1", k, so_b, valid_b, exp_b[k]); end
            n_checks++; if (last_b !== (k == W-1) || ready_b !== (k == W-1)) begin n_fail++; $display("[TB] FAIL lsb_last_ready[%0d]: got last=%b ready=%b expected %b", k, last_b, ready_b, k == W-1); end
            @(negedge clk);
        end
        en_b = 0;
    endtask

    task automatic test_random();
        bit exp_so, exp_valid, exp_last, exp_ready, acc, dummy;
        rst = 1'b1; lv_a = 0; en_a = 0;
        m_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            rst  = ($urandom_range(0, 59) == 0);
            lv_a = $urandom_range(0, 1);
            en_a = ($urandom_range(0, 3) != 0);
            pi_a = W'($urandom);
            if (rst) m_q.delete();
            exp_valid = (m_q.size() != 0);
            exp_so    = exp_valid ? m_q[0] : 1'b0;
            exp_last  = (m_q.size() == 1);
            exp_ready = !rst && (m_q.size() == 0 || (m_q.size() == 1 && en_a));
            #1;
            n_checks++;
            if (so_a !== exp_so || valid_a !== exp_valid || last_a !== exp_last || ready_a !== exp_ready) begin
                n_fail++;
                $display("[TB] FAIL random[%0d]: got so=%b valid=%b last=%b ready=%b expected so=%b valid=%b last=%b ready=%b",
                         k, so_a, valid_a, last_a, ready_a, exp_so, exp_valid, exp_last, exp_ready);
            end
            acc = lv_a && exp_ready;
            @(posedge clk);
            if (!rst) begin
                if (en_a && m_q.size() != 0) dummy = m_q.pop_front();
                if (acc) model_load(pi_a);
            end
            @(negedge clk);
        end
        rst = 1'b0; lv_a = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_loopback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
